// File: rtl/issue_scoreboard.sv
// In-order multi-issue scoreboard: per-register pending/owner table,
// per-unit busy state, hazard-checked grants and a slot-0 stall counter.
module issue_scoreboard #(
    parameter int ISSUE_W = 2,
    parameter int NUM_FU  = 3,
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int FUW     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ISSUE_W-1:0]        dec_valid,
    input  logic [ISSUE_W*AW-1:0]     dec_rs1,
    input  logic [ISSUE_W*AW-1:0]     dec_rs2,
    input  logic [ISSUE_W-1:0]        dec_rs1_en,
    input  logic [ISSUE_W-1:0]        dec_rs2_en,
    input  logic [ISSUE_W*AW-1:0]     dec_rd,
    input  logic [ISSUE_W-1:0]        dec_rd_en,
    input  logic [ISSUE_W*NUM_FU-1:0] dec_fu_mask,
    input  logic [ISSUE_W-1:0]        dec_serial,
    input  logic                      flush,
    input  logic [NUM_FU-1:0]         fu_done,
    output logic [ISSUE_W-1:0]        issue_grant,
    output logic [ISSUE_W*NUM_FU-1:0] issue_fu,
    output logic [NUM_FU-1:0]         fu_busy,
    output logic [NREG-1:0]           pend_vec,
    output logic [31:0]               stall_cnt
);

    localparam int RSZ = 2 ** AW;

    logic [RSZ-1:0]    pend;
    logic [FUW-1:0]    owner [RSZ];
    logic [NUM_FU-1:0] busy;
    logic [31:0]       stall_q;

    logic [ISSUE_W-1:0]        grant;
    logic [ISSUE_W*NUM_FU-1:0] fu_sel;
    logic [FUW-1:0]            fu_idx [ISSUE_W];
    logic [NUM_FU-1:0]         claimed;
    logic [NUM_FU-1:0]         avail;
    logic [NUM_FU-1:0]         pick;
    logic [RSZ-1:0]            grp_wr;
    logic [AW-1:0]             rs1;
    logic [AW-1:0]             rs2;
    logic [AW-1:0]             rd;
    logic [FUW-1:0]            idx;
    logic                      chain;
    logic                      ok;
    logic                      idle;

    assign idle = (busy == '0) && (pend == '0);

    // Slots are walked oldest first; chain drops once a slot fails
    // or a serialising slot issues, so younger slots stay in order.
    always_comb begin
        grant   = '0;
        fu_sel  = '0;
        claimed = '0;
        grp_wr  = '0;
        chain   = 1'b1;
        avail   = '0;
        pick    = '0;
        rs1     = '0;
        rs2     = '0;
        rd      = '0;
        idx     = '0;
        ok      = 1'b0;
        for (int i = 0; i < ISSUE_W; i++) fu_idx[i] = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            rs1   = dec_rs1[i*AW +: AW];
            rs2   = dec_rs2[i*AW +: AW];
            rd    = dec_rd[i*AW +: AW];
            avail = dec_fu_mask[i*NUM_FU +: NUM_FU] & ~busy & ~claimed;
            pick  = '0;
            idx   = '0;
            for (int u = NUM_FU - 1; u >= 0; u--) begin
                if (avail[u]) begin
                    pick    = '0;
                    pick[u] = 1'b1;
                    idx     = FUW'(u);
                end
            end
            ok = chain && dec_valid[i] && !flush && (avail != '0);
            if (dec_rs1_en[i] && rs1 != '0 && (pend[rs1] || grp_wr[rs1]))
                ok = 1'b0;
            if (dec_rs2_en[i] && rs2 != '0 && (pend[rs2] || grp_wr[rs2]))
                ok = 1'b0;
            if (dec_rd_en[i] && rd != '0 && (pend[rd] || grp_wr[rd]))
                ok = 1'b0;
            if (dec_serial[i] && (i != 0 || !idle))
                ok = 1'b0;
            if (ok) begin
                grant[i]                    = 1'b1;
                fu_sel[i*NUM_FU +: NUM_FU]  = pick;
                fu_idx[i]                   = idx;
                claimed                     = claimed | pick;
                if (dec_rd_en[i] && rd != '0) grp_wr[rd] = 1'b1;
            end
            chain = ok && !dec_serial[i];
        end
    end

    // Done clears run before grant sets; they never touch the same
    // register or unit because a grant needs both to be free.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend    <= '0;
            busy    <= '0;
            stall_q <= '0;
            for (int r = 0; r < RSZ; r++) owner[r] <= '0;
        end else begin
            for (int u = 0; u < NUM_FU; u++) begin
                if (fu_done[u] && busy[u]) begin
                    busy[u] <= 1'b0;
                    for (int r = 0; r < RSZ; r++) begin
                        if (pend[r] && owner[r] == FUW'(u)) pend[r] <= 1'b0;
                    end
                end
            end
            for (int i = 0; i < ISSUE_W; i++) begin
                if (grant[i]) begin
                    for (int u = 0; u < NUM_FU; u++) begin
                        if (fu_sel[i*NUM_FU + u]) busy[u] <= 1'b1;
                    end
                    if (dec_rd_en[i] && dec_rd[i*AW +: AW] != '0) begin
                        pend[dec_rd[i*AW +: AW]]  <= 1'b1;
                        owner[dec_rd[i*AW +: AW]] <= fu_idx[i];
                    end
                end
            end
            if (dec_valid[0] && !grant[0]) stall_q <= stall_q + 32'd1;
        end
    end

    assign issue_grant = grant;
    assign issue_fu    = fu_sel;
    assign fu_busy     = busy;
    assign pend_vec    = pend[NREG-1:0];
    assign stall_cnt   = stall_q;

endmodule
